im_loader: RTL and testbench

- Writer-side counterpart of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Drives a word-write port into the instruction store at consecutive word addresses, so programs load at run time instead of from a fixed hex file.
- Sits between the host/serial byte source and the instruction store's write port; the CPU fetch path is held off while busy is high.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/im_word_packer.sv | 40 ++++
 rtl/im_loader.sv | 149 ++++++++++++++
 tb/tb_im_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the instruction-memory loader path.
package cpu_mem_pkg;

  localparam int unsigned IM_DEPTH   = 128;
  localparam int unsigned IM_AW      = 7;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } im_state_t;

endpackage

// File: rtl/im_word_packer.sv
// Collects four stream bytes into one 32-bit instruction word.
module im_word_packer
  import cpu_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0] byte_idx;

  // Byte index and assembly register; cleared on reset and on each new load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (shift) begin
      byte_idx <= byte_idx + 2'd1;
      if (BIG_ENDIAN) begin
        word <= {word[23:0], byte_data};
      end else begin
        word <= {byte_data, word[31:8]};
      end
    end
  end

  // The transfer landing in the last byte slot completes the word.
  always_comb begin
    word_full = shift && (byte_idx == LAST_IDX);
  end

endmodule

// File: rtl/im_loader.sv
// Byte-stream loader that writes consecutive 32-bit words into the
// instruction store while holding the fetch path off via busy.
module im_loader
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = IM_DEPTH,
  parameter int unsigned AW         = IM_AW,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len_words,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          im_we,
  output logic [31:0]   im_waddr,
  output logic [31:0]   im_wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  im_state_t   state;
  im_state_t   state_next;

  logic [AW:0]   len;
  logic [AW:0]   len_clamped;
  logic [AW:0]   count_inc;
  logic [AW-1:0] idx;
  logic          start_accept;
  logic          shift;
  logic          word_full;
  logic [31:0]   word;
  logic [31:0]   waddr_cur;
  logic [31:0]   waddr_q;
  logic [31:0]   wdata_q;

  im_word_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_accept),
    .shift     (shift),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  // Requested length clamped to the store size so the index never wraps.
  always_comb begin
    len_clamped = (len_words > DEPTH_W) ? DEPTH_W : len_words;
    count_inc   = word_count + ONE_W;
    waddr_cur   = 32'({idx, 2'b00});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (len_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (word_full) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (count_inc == len) ? DONE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and handshake qualifiers.
  always_comb begin
    byte_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    im_we        = 1'b0;
    start_accept = 1'b0;
    unique case (state)
      IDLE:  start_accept = start;
      LOAD:  begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        busy  = 1'b1;
        im_we = 1'b1;
      end
      DONE:  begin
        done         = 1'b1;
        start_accept = start;
      end
      default: ;
    endcase
    shift = byte_valid && byte_ready;
  end

  // Length latch, word counter/index, and hold registers for the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      word_count <= '0;
      idx        <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else if (start_accept) begin
      len        <= len_clamped;
      word_count <= '0;
      idx        <= '0;
    end else if (state == WRITE) begin
      word_count <= count_inc;
      idx        <= idx + 1'b1;
      waddr_q    <= waddr_cur;
      wdata_q    <= word;
    end
  end

  // Write port shows the live word during WRITE and the last written one otherwise.
  always_comb begin
    if (state == WRITE) begin
      im_waddr = waddr_cur;
      im_wdata = word;
    end else begin
      im_waddr = waddr_q;
      im_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomised bench for im_loader: one big-endian and one little-endian
// instance share the stimulus; a stream-level model predicts every write.
module tb_im_loader;

  localparam int unsigned AW     = 7;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned BUDGET = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [AW:0] len_words;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        be_ready, be_we, be_busy, be_done;
  logic [31:0] be_waddr, be_wdata;
  logic [AW:0] be_wc;
  logic        le_ready, le_we, le_busy, le_done;
  logic [31:0] le_waddr, le_wdata;
  logic [AW:0] le_wc;

  im_loader #(.DEPTH(DEPTH), .AW(AW), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(be_ready),
    .im_we(be_we), .im_waddr(be_waddr), .im_wdata(be_wdata),
    .busy(be_busy), .done(be_done), .word_count(be_wc)
  );

  im_loader #(.DEPTH(DEPTH), .AW(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_ready),
    .im_we(le_we), .im_waddr(le_waddr), .im_wdata(le_wdata),
    .busy(le_busy), .done(le_done), .word_count(le_wc)
  );

  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [7:0]  stream[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int unsigned i, input bit big);
    logic [7:0] b0, b1, b2, b3;
    b0 = stream[4*i];
    b1 = stream[4*i+1];
    b2 = stream[4*i+2];
    b3 = stream[4*i+3];
    return big ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  task automatic check_reset_state();
    chk("rst_be_ready", be_ready, 0);  chk("rst_le_ready", le_ready, 0);
    chk("rst_be_we",    be_we,    0);  chk("rst_le_we",    le_we,    0);
    chk("rst_be_busy",  be_busy,  0);  chk("rst_le_busy",  le_busy,  0);
    chk("rst_be_done",  be_done,  0);  chk("rst_le_done",  le_done,  0);
    chk("rst_be_addr",  be_waddr, 0);  chk("rst_le_addr",  le_waddr, 0);
    chk("rst_be_data",  be_wdata, 0);  chk("rst_le_data",  le_wdata, 0);
    chk("rst_be_wc",    be_wc,    0);  chk("rst_le_wc",    le_wc,    0);
  endtask

  // mode: 0 back-to-back, 1 valid toggling, 2 random valid.
  // abort_at: nonzero asserts reset (together with start) after that many bytes.
  // poke: pulse a start mid-load, which must be ignored.
  task automatic run_load(input int unsigned len, input int unsigned mode,
                          input int unsigned abort_at, input bit poke);
    int unsigned nwords, consumed, nbe, nle, cyc;
    bit prev_complete, finished, poked, aborting, toggle, xfer;
    nwords = (len > DEPTH) ? DEPTH : len;
    consumed = 0; nbe = 0; nle = 0; cyc = 0;
    prev_complete = 0; finished = 0; poked = 0; aborting = 0; toggle = 0;
    while (stream.size() < 4*nwords + 8) stream.push_back(8'($urandom));
    @(negedge clk);
    start      = 1'b1;
    len_words  = (AW + 1)'(len);
    byte_valid = 1'b0;
    while (!finished) begin
      @(negedge clk);
      if (aborting) begin
        reset = 1'b0;
        start = 1'b0;
        check_reset_state();
        chk("wr_before_reset", nbe, abort_at / 4);
        return;
      end
      if (cyc == 0) begin
        chk("done_first", be_done, nwords == 0);
        chk("busy_first", be_busy, nwords != 0);
      end
      if (be_we) begin
        chk("we_latency", prev_complete, 1);
        chk("ready_in_write", be_ready, 0);
        if (nbe < nwords) begin
          chk("be_addr", be_waddr, 4*nbe);
          chk("be_data", be_wdata, exp_word(nbe, 1'b1));
        end else begin
          chk("extra_we_be", be_we, 0);
        end
        nbe++;
      end
      if (le_we) begin
        if (nle < nwords) begin
          chk("le_addr", le_waddr, 4*nle);
          chk("le_data", le_wdata, exp_word(nle, 1'b0));
        end else begin
          chk("extra_we_le", le_we, 0);
        end
        nle++;
      end
      if (be_done) begin
        finished = 1;
      end else if (cyc >= BUDGET) begin
        chk("timeout", be_done, 1);
        finished = 1;
      end else begin
        start = 1'b0;
        case (mode)
          0:       byte_valid = 1'b1;
          1:       begin toggle = !toggle; byte_valid = toggle; end
          default: byte_valid = 1'($urandom_range(0, 1));
        endcase
        byte_data = stream[consumed];
        if (poke && !poked && consumed == 2) begin
          start     = 1'b1;
          len_words = (AW + 1)'(1);
          poked     = 1;
        end
        if (abort_at != 0 && consumed == abort_at) begin
          reset      = 1'b1;
          start      = 1'b1;
          byte_valid = 1'b0;
          aborting   = 1;
        end
        xfer = byte_valid && be_ready;
        prev_complete = xfer && ((consumed + 1) % 4 == 0);
        if (xfer) consumed++;
        cyc++;
      end
    end
    chk("nwr_be", nbe, nwords);
    chk("nwr_le", nle, nwords);
    chk("be_wc", be_wc, nwords);
    chk("le_wc", le_wc, nwords);
    chk("consumed", consumed, 4*nwords);
    chk("ready_done", be_ready, 0);
    chk("busy_done", be_busy, 0);
    byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_we", be_we | le_we, 0);
      chk("post_ready", be_ready | le_ready, 0);
      chk("post_done", be_done, 1);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    stream = '{8'h3C, 8'h08, 8'h10, 8'h01, 8'h20, 8'h09, 8'h00, 8'h04};
    run_load(2, 0, 0, 1'b0);

    stream = '{8'h01, 8'h10, 8'h08, 8'h3C};
    run_load(1, 0, 0, 1'b0);

    stream.delete();
    run_load(5, 1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      stream.delete();
      run_load($urandom_range(1, 20), 2, 0, i == 1);
    end

    stream.delete();
    run_load(200, 0, 0, 1'b0);

    stream.delete();
    run_load(0, 0, 0, 1'b0);

    stream.delete();
    run_load(2, 0, 6, 1'b0);
    stream.delete();
    run_load(1, 2, 0, 1'b0);

    stream.delete();
    run_load(128, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
